// File: rtl/spi_apb_sequencer.sv
// spi_apb_sequencer
//   Two-requester front end that turns simple register commands into APB
//   transfers to an SPI peripheral. Round-robin arbitration in IDLE, then a
//   standard SETUP/ACCESS APB cycle; completion is reported with a one-cycle
//   DONE pulse to the requester that owned the transfer.
//
//   Optional feature: define SPI_SEQ_TIMEOUT_EN to abort an ACCESS phase that
//   sees no PREADY for TIMEOUT_CYC cycles (DONE pulses with o_ERR=1).
//
// Ports
//   i_PCLK, i_PRESETn          clock, async active-low reset
//   i_REQx/i_WRx/i_REGx/i_WDATAx  command from requester x (x = 0,1)
//   o_GNTx                     combinational accept (REQ & GNT = accepted)
//   o_DONEx, o_RDATA, o_ERR    registered completion, read data, timeout flag
//   o_PSEL..o_PWDATA           APB master outputs
//   i_PRDATA, i_PREADY         APB slave response
module spi_apb_sequencer #(
    parameter logic [9:0] BASE_ADDR   = 10'h001,
    parameter int         TIMEOUT_CYC = 16
) (
    input  logic        i_PCLK,
    input  logic        i_PRESETn,
    input  logic        i_REQ0,
    input  logic        i_REQ1,
    input  logic        i_WR0,
    input  logic        i_WR1,
    input  logic [1:0]  i_REG0,
    input  logic [1:0]  i_REG1,
    input  logic [7:0]  i_WDATA0,
    input  logic [7:0]  i_WDATA1,
    output logic        o_GNT0,
    output logic        o_GNT1,
    output logic        o_DONE0,
    output logic        o_DONE1,
    output logic [7:0]  o_RDATA,
    output logic        o_PSEL,
    output logic        o_PENABLE,
    output logic        o_PWRITE,
    output logic [15:0] o_PADDR,
    output logic [7:0]  o_PWDATA,
    input  logic [7:0]  i_PRDATA,
    input  logic        i_PREADY,
    output logic        o_ERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  reg_q, reg_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        id_q, id_d;
    logic        prio_q, prio_d;     // requester that wins a tie
    logic [1:0]  done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        timeout;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // Fires on the last allowed ACCESS cycle when PREADY is still low.
    assign timeout = (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
    // ACCESS waits forever in this build.
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    // A requester whose DONE is high this cycle sits out arbitration, so the
    // other one can take a back-to-back grant.
    logic req0_v, req1_v, arb_en;
    assign req0_v = i_REQ0 & ~done_q[0];
    assign req1_v = i_REQ1 & ~done_q[1];
    assign arb_en = (state_q == IDLE) & i_PRESETn;
    assign o_GNT0 = arb_en & req0_v & (~req1_v | ~prio_q);
    assign o_GNT1 = arb_en & req1_v & (~req0_v |  prio_q);

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        id_d    = id_q;
        prio_d  = prio_q;
        done_d  = 2'b00;
        err_d   = 1'b0;
        rdata_d = rdata_q;
`ifdef SPI_SEQ_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (o_GNT0 | o_GNT1) begin
                    wr_d    = o_GNT1 ? i_WR1    : i_WR0;
                    reg_d   = o_GNT1 ? i_REG1   : i_REG0;
                    wdata_d = o_GNT1 ? i_WDATA1 : i_WDATA0;
                    id_d    = o_GNT1;
                    prio_d  = o_GNT0;   // other requester wins next tie
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef SPI_SEQ_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ACCESS: begin
                if (i_PREADY) begin
                    if (!wr_q) rdata_d = i_PRDATA;
                    done_d  = id_q ? 2'b10 : 2'b01;
                    state_d = IDLE;
                end else if (timeout) begin
                    done_d  = id_q ? 2'b10 : 2'b01;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
`ifdef SPI_SEQ_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            reg_q   <= 2'b00;
            wdata_q <= 8'h00;
            id_q    <= 1'b0;
            prio_q  <= 1'b0;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
`ifdef SPI_SEQ_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            id_q    <= id_d;
            prio_q  <= prio_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef SPI_SEQ_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // APB outputs decode straight from state so a reset clears them at once.
    logic busy;
    assign busy      = (state_q != IDLE);
    assign o_PSEL    = busy;
    assign o_PENABLE = (state_q == ACCESS);
    assign o_PWRITE  = busy & wr_q;
    assign o_PADDR   = busy ? {BASE_ADDR, 2'b00, reg_q, 2'b00} : 16'h0000;
    assign o_PWDATA  = (busy & wr_q) ? wdata_q : 8'h00;
    assign o_DONE0   = done_q[0];
    assign o_DONE1   = done_q[1];
    assign o_ERR     = err_q;
    assign o_RDATA   = rdata_q;

endmodule

// File: tb/tb_spi_apb_sequencer.sv
// Scoreboard bench for spi_apb_sequencer: stimulus pushes expected grants,
// SETUP-phase bus values and completions into queues; a monitor pops and
// compares as the DUT presents them. Build with SPI_SEQ_TIMEOUT_EN defined
// to exercise the timeout path.
module tb_spi_apb_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
    logic [1:0]  reg0 = 0, reg1 = 0;
    logic [7:0]  wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, done0, done1, psel, penable, pwrite, err;
    logic [7:0]  rdata, pwdata;
    logic [15:0] paddr;
    logic [7:0]  prdata = 0;
    logic        pready = 0;

    always #5 clk = ~clk;

    spi_apb_sequencer #(.BASE_ADDR(10'h001), .TIMEOUT_CYC(16)) dut (
        .i_PCLK(clk), .i_PRESETn(rst_n),
        .i_REQ0(req0), .i_REQ1(req1), .i_WR0(wr0), .i_WR1(wr1),
        .i_REG0(reg0), .i_REG1(reg1), .i_WDATA0(wdata0), .i_WDATA1(wdata1),
        .o_GNT0(gnt0), .o_GNT1(gnt1), .o_DONE0(done0), .o_DONE1(done1),
        .o_RDATA(rdata), .o_PSEL(psel), .o_PENABLE(penable), .o_PWRITE(pwrite),
        .o_PADDR(paddr), .o_PWDATA(pwdata), .i_PRDATA(prdata), .i_PREADY(pready),
        .o_ERR(err)
    );

    typedef struct { logic id; logic err; logic [7:0] rdata; int acc; } done_t;
    typedef struct { logic [15:0] addr; logic wr; logic [7:0] wdata; } setup_t;

    done_t  exp_done[$];
    setup_t exp_setup[$];
    int     exp_gnt[$];
    int     checks = 0, errors = 0;
    logic [7:0] last_rd = 8'h00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // APB slave: PREADY in the slv_delay-th ACCESS cycle; 0 means never.
    int slv_delay = 1, slv_cnt = 0;
    always @(negedge clk) begin
        if (psel && penable) begin
            pready = (slv_delay != 0) && (slv_cnt == slv_delay - 1);
            slv_cnt++;
        end else begin
            pready = 1'b0;
            slv_cnt = 0;
        end
    end

    // Monitor
    setup_t cur;
    int     acc_meas = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt0 || gnt1) begin
                chk("gnt_onehot", {gnt0, gnt1} == 2'b11, 0);
                if (exp_gnt.size() == 0) chk("gnt_unexpected", 1, 0);
                else chk("gnt_order", gnt1, exp_gnt.pop_front());
            end
            if (psel && !penable) begin
                cur = '{paddr, pwrite, pwdata};
                acc_meas = 0;
                if (exp_setup.size() == 0) chk("setup_unexpected", 1, 0);
                else begin
                    setup_t e;
                    e = exp_setup.pop_front();
                    chk("setup_bus", {paddr, pwrite, pwdata}, {e.addr, e.wr, e.wdata});
                end
            end else if (psel && penable) begin
                acc_meas++;
                chk("access_stable", {paddr, pwrite, pwdata}, {cur.addr, cur.wr, cur.wdata});
            end
            if (done0 || done1) begin
                chk("done_onehot", {done0, done1} == 2'b11, 0);
                chk("done_bus_idle", {psel, penable, pwrite, paddr, pwdata}, 0);
                if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    done_t d;
                    d = exp_done.pop_front();
                    chk("done_id", done1, d.id);
                    chk("done_err", err, d.err);
                    chk("done_rdata", rdata, d.rdata);
                    chk("access_cycles", acc_meas, d.acc);
                end
            end
        end
    end

    task automatic drive(input bit id, input bit r, input bit wr, input logic [1:0] rg,
                         input logic [7:0] wd);
        if (id) begin req1 = r; wr1 = wr; reg1 = rg; wdata1 = wd; end
        else    begin req0 = r; wr0 = wr; reg0 = rg; wdata0 = wd; end
    endtask

    task automatic expect_start(input bit id, input bit wr, input logic [1:0] rg,
                                input logic [7:0] wd);
        exp_gnt.push_back(int'(id));
        exp_setup.push_back('{{10'h001, 2'b00, rg, 2'b00}, wr, wr ? wd : 8'h00});
    endtask

    task automatic expect_done(input bit id, input bit e, input int acc);
        done_t d;
        d.id = id; d.err = e; d.rdata = last_rd; d.acc = acc;
        exp_done.push_back(d);
    endtask

    task automatic wait_gnt(input bit id);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (id ? gnt1 : gnt0) begin ok = 1; break; end
        end
        if (!ok) chk("gnt_wait_timeout", 0, 1);
    endtask

    // Full transfer; also checks acceptance-to-DONE latency.
    task automatic xfer(input bit id, input bit wr, input logic [1:0] rg,
                        input logic [7:0] wd, input logic [7:0] prd, input int dly);
        int n = 0;
        slv_delay = dly;
        prdata = prd;
        expect_start(id, wr, rg, wd);
        if (!wr) last_rd = prd;
        expect_done(id, 1'b0, dly);
        drive(id, 1, wr, rg, wd);
        wait_gnt(id);
        @(posedge clk); #1;
        drive(id, 0, wr, rg, ~wd);     // post-acceptance changes must not matter
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (done0 || done1) break;
        end
        chk("done_latency", n, 2 + dly);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with a request pending to confirm GNT is held off.
        req0 = 1;
        @(negedge clk);
        chk("reset_outputs", {gnt0, gnt1, done0, done1, err, psel, penable, pwrite,
                              paddr, pwdata, rdata}, 0);
        req0 = 0;
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;

        // Write: PADDR 0x0044, DONE 3 cycles after acceptance.
        xfer(0, 1, 2'd1, 8'hA5, 8'h00, 1);
        // Read with PREADY in the 4th ACCESS cycle.
        xfer(1, 0, 2'd0, 8'h00, 8'h3C, 4);

        // Arbitration: both held, expect 0,1,0,1.
        slv_delay = 1;
        for (int k = 0; k < 2; k++) begin
            expect_start(0, 1, 2'd2, 8'h11); expect_done(0, 0, 1);
            expect_start(1, 1, 2'd3, 8'h22); expect_done(1, 0, 1);
        end
        drive(0, 1, 1, 2'd2, 8'h11);
        drive(1, 1, 1, 2'd3, 8'h22);
        begin
            int g = 0;
            for (int i = 0; i < 100 && g < 4; i++) begin
                @(negedge clk);
                if (gnt0 || gnt1) g++;
            end
            chk("arb_grant_count", g, 4);
        end
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
        for (int i = 0; i < 60 && exp_done.size() != 0; i++) @(negedge clk);
        @(posedge clk); #1;

        // Reset during ACCESS: immediate abort, no DONE.
        slv_delay = 0;
        expect_start(0, 0, 2'd1, 8'h00);
        drive(0, 1, 0, 2'd1, 8'h00);
        wait_gnt(0);
        @(posedge clk); #1 req0 = 0;
        begin
            bit seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (psel && penable) begin seen = 1; break; end
            end
            chk("reached_access", seen, 1);
        end
        #2 rst_n = 0;
        #1 chk("reset_abort", {gnt0, gnt1, done0, done1, err, psel, penable, pwrite,
                               paddr, pwdata, rdata}, 0);
        last_rd = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        xfer(0, 0, 2'd2, 8'h00, 8'h5A, 2);

`ifdef SPI_SEQ_TIMEOUT_EN
        // PREADY stuck low: abort after 16 ACCESS cycles with ERR.
        slv_delay = 0;
        expect_start(0, 1, 2'd3, 8'h77);
        expect_done(0, 1, 16);
        drive(0, 1, 1, 2'd3, 8'h77);
        wait_gnt(0);
        @(posedge clk); #1 req0 = 0;
        for (int i = 0; i < 60 && exp_done.size() != 0; i++) @(negedge clk);
        @(posedge clk); #1;
`else
        // PREADY stuck low: the bus stays in ACCESS.
        slv_delay = 0;
        expect_start(0, 1, 2'd3, 8'h77);
        drive(0, 1, 1, 2'd3, 8'h77);
        wait_gnt(0);
        @(posedge clk); #1 req0 = 0;
        repeat (30) @(negedge clk);
        chk("no_timeout_psel", {psel, penable, done0, err}, 4'b1100);
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
`endif

        repeat (3) @(negedge clk);
        chk("exp_done_drained", exp_done.size(), 0);
        chk("exp_setup_drained", exp_setup.size(), 0);
        chk("exp_gnt_drained", exp_gnt.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_apb_sequencer.md
SPI_APB_SEQUENCER -- requirements
Module: spi_apb_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 10'h001, meaning the SPI peripheral base placed on o_PADDR[15:6].
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16, meaning the ACCESS-phase cycle limit used when the timeout feature is compiled in.
REQ-003 SHALL have port i_PCLK  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_PRESETn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports i_REQ0 / i_REQ1  in  1  transfer request from requester 0 / 1.
REQ-006 SHALL have ports i_WR0 / i_WR1  in  1  1 = write, 0 = read.
REQ-007 SHALL have ports i_REG0 / i_REG1  in  2  SPI register index: 0 CONFIG/STATE, 1 TX/RX, 2 RX, 3 CMD.
REQ-008 SHALL have ports i_WDATA0 / i_WDATA1  in  8  write data.
REQ-009 SHALL have ports o_GNT0 / o_GNT1  out  1  request accepted this cycle.
REQ-010 SHALL have ports o_DONE0 / o_DONE1  out  1  one-cycle completion pulse.
REQ-011 SHALL have port o_RDATA  out  8  read data, valid while o_DONEx=1.
REQ-012 SHALL have ports o_PSEL, o_PENABLE, o_PWRITE  out  1 each; o_PADDR  out  16; o_PWDATA  out  8: APB master outputs.
REQ-013 SHALL have ports i_PRDATA  in  8 and i_PREADY  in  1: APB slave responses.
REQ-014 SHALL have port o_ERR  out  1  timeout abort flag, paired with o_DONEx.

Function
REQ-015 SHALL implement an FSM with states IDLE, SETUP and ACCESS.
REQ-016 In IDLE, the FSM SHALL assert o_GNTx combinationally for exactly one requester with i_REQx=1; the transfer is accepted when REQ&GNT.
REQ-017 When both requesters are active, the FSM SHALL grant round-robin: the requester not granted last wins; after reset, requester 0 has priority.
REQ-018 On acceptance, the FSM SHALL latch WR, REG, WDATA and the requester id, then enter SETUP on the next cycle.
REQ-019 In SETUP, outputs SHALL be o_PSEL=1, o_PENABLE=0, o_PADDR={BASE_ADDR,2'b00,REG,2'b00}, and o_PWRITE/o_PWDATA from the latched command; o_PWDATA SHALL be 0 for reads.
REQ-020 SETUP SHALL always advance to ACCESS after one cycle.
REQ-021 In ACCESS, o_PSEL=1 and o_PENABLE=1 SHALL be held, with address and data stable, until i_PREADY=1 is sampled.
REQ-022 On i_PREADY=1 in ACCESS, the FSM SHALL: register o_RDATA<=i_PRDATA for reads (unchanged for writes), pulse o_DONEx for the owning requester in the next cycle, and return to IDLE.
REQ-023 o_DONEx SHALL be registered, and o_GNTx SHALL NOT be asserted in the same cycle for the same requester; a requester holding i_REQx through o_DONEx is re-arbitrated normally.
REQ-024 In IDLE, o_PSEL, o_PENABLE, o_PWRITE, o_PADDR and o_PWDATA SHALL be 0.
REQ-025 Minimum transfer SHALL be 3 cycles (IDLE-accept, SETUP, ACCESS with PREADY); back-to-back grants SHALL be possible in the cycle o_DONEx is high.
REQ-026 Changes of i_REQx/i_WDATAx while not granted SHALL have no effect.

Reset
REQ-027 While i_PRESETn=0, the block SHALL be in IDLE with o_GNTx, o_DONEx, o_ERR, o_PSEL, o_PENABLE and o_PWRITE all 0, o_PADDR=0, o_PWDATA=0, o_RDATA=0, and the round-robin pointer on requester 0.
REQ-028 Reset asserted mid-transfer SHALL abort immediately and asynchronously with no o_DONEx; after release, the first edge samples IDLE.

Configuration
REQ-029 With SPI_SEQ_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles; if TIMEOUT_CYC cycles elapse without i_PREADY, the FSM SHALL return to IDLE, pulse o_DONEx together with o_ERR=1, and leave o_RDATA unchanged.
REQ-030 Without SPI_SEQ_TIMEOUT_EN, ACCESS SHALL wait indefinitely and o_ERR SHALL be tied to 0.

Verification
REQ-031 Write test: BASE_ADDR=10'h001, requester 0 writes REG=1 data 8'hA5, PREADY high in ACCESS -> SETUP shows PADDR=16'h0044, PWRITE=1, PWDATA=8'hA5; o_DONE0 pulses 3 cycles after acceptance.
REQ-032 Read test: requester 1 reads REG=0, PRDATA=8'h3C, PREADY delayed 4 ACCESS cycles -> PENABLE held 4 cycles, address stable; o_DONE1 with o_RDATA=8'h3C.
REQ-033 Arbitration test: both requests held continuously -> grant order 0,1,0,1; no cycle has both GNT high.
REQ-034 Reset test: i_PRESETn dropped during ACCESS -> all outputs 0 immediately, no DONE; a fresh request after release completes normally.
REQ-035 Timeout test: with SPI_SEQ_TIMEOUT_EN, PREADY stuck at 0 -> after 16 ACCESS cycles, o_DONE0=1 and o_ERR=1, PSEL=0; without the macro, PSEL stays 1.
